adc_offset_calibrator: RTL and testbench
========================================

# adc_offset_calibrator

Background offset-calibration block for the 10-bit ADC datapath. On request it averages 2^LOG2_N raw ADC codes taken while the front end sees its calibration input, nominally mid-scale. It compares the average against a target code and produces a saturated two's-complement offset word. The downstream offset-correction stage adds this word to every live conversion.

## Interface
- LOG2_N, default 4: log2 of the number of samples averaged (N = 16 by default); legal range 1..6.
- TARGET, default 10'd512: expected code for the calibration input.

- clk  input  1  system clock; all logic is on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  request a calibration run; sampled only in IDLE.
- abort  input  1  cancel a run in progress; offset is left unchanged.
- sample_valid  input  1  sample carries a new conversion result this cycle.
- sample  input  10  unsigned raw ADC code.
- offset  output  10  two's-complement correction word, range -512..+511; registered.
- busy  output  1  high in ACCUM and COMPUTE.
- done  output  1  one-cycle pulse when offset has just been updated.
- sat  output  1  the last completed run clamped its result; registered.

## Operation
- States: IDLE, ACCUM, COMPUTE.
- IDLE:
  - start=1 moves to ACCUM next cycle.
  - The accumulator (10+LOG2_N bits, unsigned) and the sample counter (LOG2_N+1 bits) clear on that same edge.
- ACCUM:
  - Each cycle with sample_valid=1 adds sample to the accumulator and increments the counter.
  - Cycles with sample_valid=0 are ignored, so gaps of any length are legal.
  - The edge that accepts the Nth sample moves to COMPUTE.
- COMPUTE, one cycle:
  - avg = acc >> LOG2_N, i.e. truncated toward zero.
  - diff = TARGET - avg, computed signed in 11 bits.
  - If diff > 511: offset=511, sat=1.
  - If diff < -512: offset=-512 (10'h200), sat=1.
  - Otherwise: offset=diff[9:0], sat=0.
  - done=1 for that one cycle. Next state is IDLE.
- abort=1 in ACCUM or COMPUTE returns to IDLE on the next edge:
  - offset and sat are not updated and done does not pulse.
  - abort takes priority over completing the run.
- start while busy is ignored, and start in the same cycle as abort is ignored.
- offset and sat hold their values between runs. A new run changes them only when it completes.
- rst_n=0 at any time, including mid-run, forces on the next edge: state=IDLE, accumulator=0, counter=0, offset=0, sat=0, busy=0, done=0.

## Timing
- Reset values: offset=10'h000, sat=0, busy=0, done=0.
- start asserted in IDLE at edge t: busy=1 from t+1. The first sample accepted is the one presented with sample_valid at edge t+1 or later; a sample coinciding with start is not counted.
- With sample_valid held high from t+1, the Nth sample is accepted at edge t+N.
- At edge t+N+1: offset, sat and done are updated, busy=0, and the block is back in IDLE.
- Latency from last accepted sample to offset valid is 1 cycle. Minimum run length is N+1 cycles after start.
- start may be reasserted in the cycle done=1 and is honoured, since the block is in IDLE then.
- The accumulator cannot overflow: N*1023 fits in 10+LOG2_N bits.

## Test plan
- Default parameters, start, then 16 samples of 500 back-to-back -> done at start+17 cycles, offset=10'h00C (+12), sat=0.
- 16 samples of 530 with sample_valid toggling every other cycle -> offset=10'h3EE (-18), done only after the 16th valid sample, busy high throughout.
- Truncation: 8×510 and 8×511, so acc=8168 and avg=510 -> offset=10'h002. Separately, 16×1023 -> offset=10'h201 (-511), sat=0.
- Saturation: 16×0 -> diff=+512 -> offset=10'h1FF, sat=1. Then a clean run of 16×512 -> offset=0, sat=0.
- Abort after 9 samples, following a run that left offset=10'h00C -> block in IDLE next cycle, no done pulse, offset stays 10'h00C. Then start issued together with abort -> ignored.
- rst_n low during ACCUM after a prior offset of 10'h3EE -> next edge: offset=0, busy=0. Then a fresh run of 16×500 -> offset=10'h00C, showing the accumulator and counter were cleared by the reset.

Source files
------------

// File: rtl/adc_offset_calibrator.sv
// Averages 2^LOG2_N calibration samples and emits a saturated offset = TARGET - average.
// Latency: offset/sat/done update one cycle after the Nth accepted sample; sample gaps stall the run.
module adc_offset_calibrator #(
    parameter int          LOG2_N = 4,
    parameter logic [9:0]  TARGET = 10'd512
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       sample_valid,
    input  logic [9:0] sample,
    output logic [9:0] offset,
    output logic       busy,
    output logic       done,
    output logic       sat
);
    localparam int ACC_W = 10 + LOG2_N;
    localparam int CNT_W = LOG2_N + 1;
    localparam int N     = 1 << LOG2_N;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    typedef enum logic [1:0] {IDLE, ACCUM, COMPUTE} state_t;

    state_t             state;
    logic [ACC_W-1:0]   acc;
    logic [CNT_W-1:0]   cnt;

    logic [9:0]         avg;
    logic signed [10:0] diff;
    logic [9:0]         offset_nxt;
    logic               sat_nxt;

    // Dropping the low LOG2_N bits is the truncating divide by N.
    assign avg = acc[ACC_W-1:LOG2_N];

    always_comb begin
        diff       = $signed({1'b0, TARGET}) - $signed({1'b0, avg});
        offset_nxt = diff[9:0];
        sat_nxt    = 1'b0;
        if (diff > 11'sd511) begin
            offset_nxt = 10'h1FF;
            sat_nxt    = 1'b1;
        end else if (diff < -11'sd512) begin
            offset_nxt = 10'h200;
            sat_nxt    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            acc    <= '0;
            cnt    <= '0;
            offset <= '0;
            sat    <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        state <= ACCUM;
                        acc   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                ACCUM: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (sample_valid) begin
                        acc <= acc + {{LOG2_N{1'b0}}, sample};
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == LAST)
                            state <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    // An abort landing on the compute cycle still discards the result.
                    if (!abort) begin
                        offset <= offset_nxt;
                        sat    <= sat_nxt;
                        done   <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_adc_offset_calibrator.sv
// Directed bench: stimulus pushes expected {offset,sat} per completed run; a monitor pops on done.
module tb_adc_offset_calibrator;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       sample_valid = 1'b0;
    logic [9:0] sample = '0;
    logic [9:0] offset;
    logic       busy;
    logic       done;
    logic       sat;

    int total = 0;
    int bad   = 0;
    logic [10:0] exp_q[$];

    adc_offset_calibrator #(.LOG2_N(4), .TARGET(10'd512)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .abort        (abort),
        .sample_valid (sample_valid),
        .sample       (sample),
        .offset       (offset),
        .busy         (busy),
        .done         (done),
        .sat          (sat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_run();
        start = 1'b1;
        step();
        start = 1'b0;
        chk("busy_after_start", busy, 1);
    endtask

    task automatic feed(input logic [9:0] v, input bit gap);
        sample_valid = 1'b1;
        sample       = v;
        step();
        sample_valid = 1'b0;
        if (gap) begin
            step();
            chk("busy_in_gap", busy, 1);
            chk("no_early_done", done, 0);
        end
    endtask

    task automatic run(input logic [9:0] a, input logic [9:0] b, input bit gap,
                       input logic [9:0] eo, input logic es);
        exp_q.push_back({eo, es});
        begin_run();
        for (int i = 0; i < 16; i++)
            feed((i < 8) ? a : b, gap && (i < 15));
        chk("busy_in_compute", busy, 1);
        chk("done_before_compute", done, 0);
        step();
        chk("done_pulse", done, 1);
        chk("busy_cleared", busy, 0);
        step();
        chk("done_one_cycle", done, 0);
    endtask

    initial begin : monitor
        logic [10:0] e;
        forever begin
            @(negedge clk);
            if (done) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: offset=%0h sat=%0b, no completion expected", offset, sat);
                end else begin
                    e = exp_q.pop_front();
                    chk("offset", offset, e[10:1]);
                    chk("sat", sat, e[0]);
                end
            end
        end
    end

    initial begin : stimulus
        repeat (3) step();
        chk("reset_offset", offset, 10'h000);
        chk("reset_sat", sat, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        rst_n = 1'b1;
        step();

        run(10'd500,  10'd500,  1'b0, 10'h00C, 1'b0);
        run(10'd530,  10'd530,  1'b1, 10'h3EE, 1'b0);
        run(10'd510,  10'd511,  1'b0, 10'h002, 1'b0);
        run(10'd1023, 10'd1023, 1'b0, 10'h201, 1'b0);
        run(10'd0,    10'd0,    1'b0, 10'h1FF, 1'b1);
        run(10'd512,  10'd512,  1'b0, 10'h000, 1'b0);
        run(10'd500,  10'd500,  1'b0, 10'h00C, 1'b0);

        // Abort mid-accumulation
        begin_run();
        for (int i = 0; i < 9; i++) feed(10'd500, 1'b0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_offset", offset, 10'h00C);
        repeat (2) step();

        // start together with abort in IDLE is ignored
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        chk("start_with_abort_busy", busy, 0);
        step();
        chk("start_with_abort_still_idle", busy, 0);

        // Abort on the compute cycle discards the would-be saturated result
        begin_run();
        for (int i = 0; i < 16; i++) feed(10'd0, 1'b0);
        chk("compute_busy", busy, 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("compute_abort_done", done, 0);
        chk("compute_abort_busy", busy, 0);
        chk("compute_abort_offset", offset, 10'h00C);
        chk("compute_abort_sat", sat, 0);
        step();

        // Reset in the middle of a run
        run(10'd530, 10'd530, 1'b0, 10'h3EE, 1'b0);
        begin_run();
        for (int i = 0; i < 5; i++) feed(10'd500, 1'b0);
        rst_n = 1'b0;
        step();
        chk("midrun_reset_offset", offset, 10'h000);
        chk("midrun_reset_busy", busy, 0);
        chk("midrun_reset_sat", sat, 0);
        chk("midrun_reset_done", done, 0);
        rst_n = 1'b1;
        step();
        run(10'd500, 10'd500, 1'b0, 10'h00C, 1'b0);

        repeat (3) step();
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
